piso_serializer: RTL and testbench
==================================

# piso_serializer

Parallel-in/serial-out stage that sits directly upstream of `shift_register` and drives its `si` input. It accepts N-bit words over a valid/ready handshake and emits each word one bit per clock on `so`. A one-word holding buffer lets words stream back-to-back with no idle bit between them. Frame-marker pulses tell downstream logic where each word starts and ends.

## Interface
- `N`, default 8: word width; must be ≥ 2.
- `LSB_FIRST`, default 0: bit order. 0 sends bit N-1 first; 1 sends bit 0 first.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `data_in`  in  N: parallel word.
- `valid_in`  in  1: `data_in` is valid.
- `ready_out`  out  1: the block can accept a word this cycle.
- `so`  out  1: serial data; connects to `shift_register.si`.
- `so_valid`  out  1: `so` carries a payload bit this cycle.
- `sof`  out  1: high on the first bit of a word.
- `eof`  out  1: high on the last bit of a word.

## Operation
- Accept condition: `valid_in && ready_out` at a rising edge.
- `ready_out = !hold_valid`. It is derived from a register only; it never depends on `valid_in`.
- Internal state:
  - `shreg[N-1:0]`: shifter.
  - `bit_cnt`: width `$clog2(N)`.
  - `hold[N-1:0]` and `hold_valid`: holding buffer.
  - FSM with states IDLE and SHIFT.
- IDLE:
  - On accept: load `shreg` from `data_in`, set `bit_cnt` to 0, go to SHIFT.
  - The holding buffer stays empty.
- SHIFT, not on the last bit (`bit_cnt != N-1`):
  - Shift `shreg` toward the output end and increment `bit_cnt`.
  - An accept writes `hold` and sets `hold_valid`.
- SHIFT, on the last bit (`bit_cnt == N-1`):
  - If `hold_valid`: load `shreg` from `hold`, clear `hold_valid`, set `bit_cnt` to 0, stay in SHIFT. No accept is possible this cycle because `ready_out` is 0.
  - Else, if an accept happens this cycle: load `shreg` directly from `data_in`, set `bit_cnt` to 0, stay in SHIFT.
  - Else: go to IDLE.
- Outputs:
  - `so` is the output-end bit of `shreg`: `shreg[N-1]` when `LSB_FIRST=0`, `shreg[0]` when `LSB_FIRST=1`.
  - `so_valid = (state == SHIFT)`.
  - `sof = so_valid && bit_cnt == 0`.
  - `eof = so_valid && bit_cnt == N-1`.
  - All outputs are decoded from registers; there is no path from any input to any output.
- Contents of `shreg` bits already shifted out are don't-care. `so` is forced to 0 in IDLE.
- If `data_in` changes while `valid_in` is high and `ready_out` is low, it is ignored until accepted; no word is lost or duplicated.

## Timing
- Reset values, asynchronous on the `rst_n` falling edge:
  - state = IDLE, `shreg` = 0, `bit_cnt` = 0, `hold` = 0, `hold_valid` = 0.
  - So `so` = 0, `so_valid` = 0, `sof` = 0, `eof` = 0, `ready_out` = 1.
- Latency: a word accepted at edge k shows its first bit on `so` in the cycle after edge k. Its last bit appears after edge k+N-1.
- Throughput: one bit per cycle. Continuous streaming happens when either:
  - each next word is accepted during the current word's first N-1 bits (it lands in `hold`), or
  - it is accepted on the last-bit cycle (direct load).
- `ready_out` falls on the edge that fills `hold`. It rises on the edge that moves `hold` into `shreg`.
- Reset asserted mid-word aborts that word immediately. After `rst_n` rises, the block is idle with `ready_out` = 1, and no partial word resumes.

## Structure
- A shared package `serial_pkg` holds:
  - the FSM state typedef (`ST_IDLE`, `ST_SHIFT`);
  - a function computing the counter width, `$clog2(N)`.
- Single module; no sub-module. The holding buffer is one register plus one flag and is not worth its own module.
- The integration top instantiates `piso_serializer` followed by `shift_register`, with `so` wired to `si`.

## Test plan
- Reset: hold `rst_n`=0 with `valid_in`=1 -> `ready_out`=1, `so`=0, `so_valid`=0, `sof`=0, `eof`=0, and nothing is accepted.
- Single word: `data_in`=8'hA5, one-cycle valid -> `so` = 1,0,1,0,0,1,0,1 over 8 cycles. `sof` is high on bit 0 and `eof` on bit 7, then `so_valid` drops to 0.
- Back-to-back: 8'hA5 then 8'h3C presented immediately with `valid_in` held -> 16 contiguous valid bits 1010_0101_0011_1100. `ready_out` is low while 8'h3C waits in `hold`. Exactly two `sof` pulses and two `eof` pulses.
- Last-bit direct load: second word 8'hFF presented first on the last-bit cycle of 8'h00 -> no gap in `so_valid`, and `so` goes from eight 0s to eight 1s.
- Reset mid-word: assert `rst_n`=0 after bit 3 of 8'hF0 -> `so_valid` and `so` go to 0 at once. After release, a new word 8'h81 serializes as 1,0,0,0,0,0,0,1.
- `LSB_FIRST`=1 with `data_in`=8'h01 -> `so` = 1 followed by seven 0s. `sof` aligns with the 1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial datapath blocks: FSM state encoding and
// counter sizing helper.
package serial_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bit-counter width for an n-bit word; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding buffer so words can
// stream back-to-back; frames each word with sof/eof markers.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] data_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic         so,
    output logic         so_valid,
    output logic         sof,
    output logic         eof
);

    localparam int unsigned     CW   = cnt_width(N);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [N-1:0]   hold_q, hold_d;
    logic           hold_valid_q, hold_valid_d;
    logic           accept;
    logic           last_bit;

    assign accept   = valid_in && !hold_valid_q;
    assign last_bit = (bit_cnt_q == LAST);

    // Next-state: load, shift, refill from hold or direct load on last bit.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!last_bit) begin
                    shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (accept) begin
                        hold_d       = data_in;
                        hold_valid_d = 1'b1;
                    end
                end else if (hold_valid_q) begin
                    shreg_d      = hold_q;
                    hold_valid_d = 1'b0;
                    bit_cnt_d    = '0;
                end else if (accept) begin
                    shreg_d   = data_in;
                    bit_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    // Outputs are pure decodes of registered state; no input-to-output path.
    assign ready_out = !hold_valid_q;
    assign so_valid  = (state_q == ST_SHIFT);
    assign so        = so_valid && (LSB_FIRST ? shreg_q[0] : shreg_q[N-1]);
    assign sof       = so_valid && (bit_cnt_q == '0);
    assign eof       = so_valid && last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus randomized
// streams checked against a word-queue reference model.
module tb_piso_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in   [2];
    logic       valid_in  [2];
    logic       ready_out [2];
    logic       so        [2];
    logic       so_valid  [2];
    logic       sof       [2];
    logic       eof       [2];

    int total = 0;
    int bad   = 0;

    piso_serializer #(.N(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in[0]),
        .valid_in (valid_in[0]),
        .ready_out(ready_out[0]),
        .so       (so[0]),
        .so_valid (so_valid[0]),
        .sof      (sof[0]),
        .eof      (eof[0])
    );

    piso_serializer #(.N(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in[1]),
        .valid_in (valid_in[1]),
        .ready_out(ready_out[1]),
        .so       (so[1]),
        .so_valid (so_valid[1]),
        .sof      (sof[1]),
        .eof      (eof[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit idx (0 = first on the wire) of word w for the given order.
    function automatic logic exp_bit(input logic [7:0] w, input int idx, input bit lsb);
        return lsb ? w[idx] : w[7-idx];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            valid_in[d] = 1'b1;
            data_in[d]  = 8'hFF;
        end
        repeat (3) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                total++;
                if ({ready_out[d], so[d], so_valid[d], sof[d], eof[d]} !== 5'b10000) begin
                    bad++;
                    $display("FAIL reset_outputs dut%0d: got %b expected 10000", d,
                             {ready_out[d], so[d], so_valid[d], sof[d], eof[d]});
                end
            end
        end
        valid_in[0] = 1'b0;
        valid_in[1] = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (so_valid[d] !== 1'b0 || ready_out[d] !== 1'b1) begin
                bad++;
                $display("FAIL reset_no_accept dut%0d: so_valid=%b ready=%b expected 0,1",
                         d, so_valid[d], ready_out[d]);
            end
        end
    endtask

    task automatic test_single;
        logic [3:0] exp;
        valid_in[0] = 1'b1;
        data_in[0]  = 8'hA5;
        tick();
        valid_in[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {exp_bit(8'hA5, i, 1'b0), 1'b1, (i == 0), (i == 7)};
            total++;
            if ({so[0], so_valid[0], sof[0], eof[0]} !== exp) begin
                bad++;
                $display("FAIL single bit%0d: got so/vld/sof/eof=%b expected %b",
                         i, {so[0], so_valid[0], sof[0], eof[0]}, exp);
            end
            tick();
        end
        total++;
        if (so_valid[0] !== 1'b0 || so[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_end: so_valid=%b so=%b expected 0,0", so_valid[0], so[0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w;
        logic [4:0] exp;
        int n_sof = 0;
        int n_eof = 0;
        valid_in[0] = 1'b1;
        data_in[0]  = 8'hA5;
        tick();
        data_in[0] = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            w   = (i < 8) ? 8'hA5 : 8'h3C;
            exp = {exp_bit(w, i % 8, 1'b0), 1'b1, (i % 8 == 0), (i % 8 == 7),
                   !(i >= 1 && i <= 7)};
            total++;
            if ({so[0], so_valid[0], sof[0], eof[0], ready_out[0]} !== exp) begin
                bad++;
                $display("FAIL b2b bit%0d: got so/vld/sof/eof/rdy=%b expected %b",
                         i, {so[0], so_valid[0], sof[0], eof[0], ready_out[0]}, exp);
            end
            if (sof[0] === 1'b1) n_sof++;
            if (eof[0] === 1'b1) n_eof++;
            if (i == 1) valid_in[0] = 1'b0;
            tick();
        end
        total++;
        if (n_sof != 2 || n_eof != 2 || so_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_frames: sof=%0d eof=%0d so_valid=%b expected 2,2,0",
                     n_sof, n_eof, so_valid[0]);
        end
    endtask

    task automatic test_direct_load;
        logic [3:0] exp;
        valid_in[0] = 1'b1;
        data_in[0]  = 8'h00;
        tick();
        valid_in[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp = {(i >= 8), 1'b1, (i % 8 == 0), (i % 8 == 7)};
            total++;
            if ({so[0], so_valid[0], sof[0], eof[0]} !== exp) begin
                bad++;
                $display("FAIL direct bit%0d: got so/vld/sof/eof=%b expected %b",
                         i, {so[0], so_valid[0], sof[0], eof[0]}, exp);
            end
            if (i == 7) begin
                total++;
                if (ready_out[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL direct_ready: got %b expected 1", ready_out[0]);
                end
                valid_in[0] = 1'b1;
                data_in[0]  = 8'hFF;
            end
            if (i == 8) valid_in[0] = 1'b0;
            tick();
        end
        total++;
        if (so_valid[0] !== 1'b0) begin
            bad++;
            $display("FAIL direct_end: so_valid=%b expected 0", so_valid[0]);
        end
    endtask

    task automatic test_reset_mid_word;
        valid_in[0] = 1'b1;
        data_in[0]  = 8'hF0;
        tick();
        valid_in[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (so[0] !== exp_bit(8'hF0, i, 1'b0) || so_valid[0] !== 1'b1) begin
                bad++;
                $display("FAIL midrst_pre bit%0d: so=%b vld=%b expected %b,1",
                         i, so[0], so_valid[0], exp_bit(8'hF0, i, 1'b0));
            end
            if (i < 3) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({so[0], so_valid[0], sof[0], eof[0], ready_out[0]} !== 5'b00001) begin
            bad++;
            $display("FAIL midrst_abort: got so/vld/sof/eof/rdy=%b expected 00001",
                     {so[0], so_valid[0], sof[0], eof[0], ready_out[0]});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        total++;
        if (so_valid[0] !== 1'b0 || ready_out[0] !== 1'b1) begin
            bad++;
            $display("FAIL midrst_no_resume: so_valid=%b ready=%b expected 0,1",
                     so_valid[0], ready_out[0]);
        end
        valid_in[0] = 1'b1;
        data_in[0]  = 8'h81;
        tick();
        valid_in[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (so[0] !== exp_bit(8'h81, i, 1'b0) || so_valid[0] !== 1'b1
                || sof[0] !== (i == 0)) begin
                bad++;
                $display("FAIL midrst_new bit%0d: so=%b vld=%b sof=%b expected %b,1,%b",
                         i, so[0], so_valid[0], sof[0], exp_bit(8'h81, i, 1'b0), (i == 0));
            end
            tick();
        end
    endtask

    task automatic test_lsb_first;
        logic [3:0] exp;
        valid_in[1] = 1'b1;
        data_in[1]  = 8'h01;
        tick();
        valid_in[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {(i == 0), 1'b1, (i == 0), (i == 7)};
            total++;
            if ({so[1], so_valid[1], sof[1], eof[1]} !== exp) begin
                bad++;
                $display("FAIL lsb bit%0d: got so/vld/sof/eof=%b expected %b",
                         i, {so[1], so_valid[1], sof[1], eof[1]}, exp);
            end
            tick();
        end
        total++;
        if (so_valid[1] !== 1'b0) begin
            bad++;
            $display("FAIL lsb_end: so_valid=%b expected 0", so_valid[1]);
        end
    endtask

    // Random stream: the model is the queue of words accepted at the handshake;
    // the wire must carry exactly their bits in order, with framing markers.
    logic [7:0] acc_q[$];
    bit         drv_done;

    task automatic test_random_stream(input int d, input int nwords);
        acc_q.delete();
        drv_done = 1'b0;
        fork
            begin
                logic [7:0] cur;
                logic       r;
                bit         acc;
                for (int w = 0; w < nwords; w++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    cur         = 8'($urandom);
                    data_in[d]  = cur;
                    valid_in[d] = 1'b1;
                    acc = 1'b0;
                    for (int t = 0; t < 40 && !acc; t++) begin
                        r = ready_out[d];
                        tick();
                        if (r) begin
                            acc_q.push_back(cur);
                            acc = 1'b1;
                        end else if ($urandom_range(0, 1) == 1) begin
                            cur        = 8'($urandom);
                            data_in[d] = cur;
                        end
                    end
                    valid_in[d] = 1'b0;
                    if (!acc) begin
                        total++;
                        bad++;
                        $display("FAIL rand_accept_timeout dut%0d word%0d", d, w);
                    end
                end
                drv_done = 1'b1;
            end
            begin
                int pos = 0;
                logic [2:0] exp;
                for (int c = 0; c < 3000; c++) begin
                    @(negedge clk);
                    if (so_valid[d] === 1'b1) begin
                        total++;
                        if (pos / 8 >= acc_q.size()) begin
                            bad++;
                            $display("FAIL rand_extra_bit dut%0d pos%0d", d, pos);
                        end else begin
                            exp = {exp_bit(acc_q[pos / 8], pos % 8, d == 1),
                                   (pos % 8 == 0), (pos % 8 == 7)};
                            if ({so[d], sof[d], eof[d]} !== exp) begin
                                bad++;
                                $display("FAIL rand_bit dut%0d pos%0d: got so/sof/eof=%b expected %b",
                                         d, pos, {so[d], sof[d], eof[d]}, exp);
                            end
                        end
                        pos++;
                    end else begin
                        total++;
                        if (so[d] !== 1'b0 || sof[d] !== 1'b0 || eof[d] !== 1'b0) begin
                            bad++;
                            $display("FAIL rand_idle dut%0d: so/sof/eof=%b expected 000",
                                     d, {so[d], sof[d], eof[d]});
                        end
                        if (drv_done && pos == acc_q.size() * 8) break;
                    end
                end
                total++;
                if (!drv_done || pos != acc_q.size() * 8) begin
                    bad++;
                    $display("FAIL rand_count dut%0d: bits=%0d expected %0d",
                             d, pos, acc_q.size() * 8);
                end
            end
        join
    endtask

    initial begin
        rst_n       = 1'b0;
        valid_in[0] = 1'b0;
        valid_in[1] = 1'b0;
        data_in[0]  = '0;
        data_in[1]  = '0;
        test_reset();
        test_single();
        tick();
        test_back_to_back();
        tick();
        test_direct_load();
        tick();
        test_reset_mid_word();
        tick();
        test_lsb_first();
        tick();
        test_random_stream(0, 40);
        test_random_stream(1, 40);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
